sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Round-robin arbiter sharing one synchronous sprite ROM read port among several display-layer renderers (mole sprites, cursor, life hearts, banners). Sits in the display path between the per-layer renderers and the single shared sprite ROM. It grants one request per cycle, drives the ROM address, and routes each returned pixel word back to the requester that issued it. A fixed-depth tag pipeline matches the ROM read latency.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 14, sprite ROM address width
- DATA_W, 12, pixel word width (BGR 4:4:4)
- ROM_LATENCY, 2, cycles from address presented to data valid at rom_data (1..4)

Ports:
- clk  in  1  system clock; single clock domain (VGA pixel clock domain)
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester read request; held until granted
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM read data, ROM_LATENCY cycles after rom_addr/rom_en
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_W  response pixel word, registered, shared by all requesters

## Operation
- Pointer last_gnt (index register). Reset value NUM_REQ-1, so requester 0 has top priority after reset.
- Each cycle, search requesters starting at (last_gnt+1) mod NUM_REQ, wrapping. The first with req=1 is granted.
- On a grant:
  - gnt[i]=1, rom_en=1, rom_addr=req_addr[i].
  - last_gnt<=i at the clock edge.
- No request:
  - gnt=0, rom_en=0, rom_addr=0.
  - last_gnt unchanged.
- Requester protocol:
  - Sees gnt[i] in the same cycle and may drop or change req/addr next cycle.
  - If still requesting next cycle, it competes again at lowest priority.
- Tag pipeline: ROM_LATENCY stages of NUM_REQ-bit one-hot tags. Stage 0 <= gnt; stage k <= stage k-1.
- Response register:
  - rsp_valid <= tag[ROM_LATENCY-1]; rsp_data <= rom_data when any tag bit is set, else holds.
- Fully pipelined: one grant and one response can occur every cycle with no bubbles.
- req bits for i ≥ NUM_REQ do not exist. Out-of-range pointer values cannot occur.

## Timing
- Grant latency: 0 cycles (combinational from req and last_gnt).
- Response latency: grant in cycle t -> rsp_valid[i]=1 in cycle t+ROM_LATENCY+1, for exactly one cycle.
- Throughput: 1 read per cycle, aggregate across requesters.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 cycles between grants.
- Reset values:
  - last_gnt=NUM_REQ-1; all tag stages=0; rsp_valid=0; rsp_data=0.
  - gnt=0, rom_en=0, rom_addr=0 while reset=1, regardless of req.
- Reset mid-operation:
  - In-flight tags are cleared; no rsp_valid is issued for reads granted before reset.
  - The first cycle after reset deasserts arbitrates normally from requester 0.
- Simultaneous events:
  - A response for requester i and a new grant to i in the same cycle are independent; both occur.
  - All requesters asserting at once are granted in rotation.

## Test plan
- Reset/idle: hold reset 3 cycles with req=4'b1111. Then gnt=0, rom_en=0, rsp_valid=0, rsp_data=0. Release reset and idle with req=0: no grants, pointer stays 3.
- Single requester: req=4'b0100, addr2=0x0123 for one cycle. Then gnt=4'b0100 and rom_addr=0x0123 in that cycle. ROM model returns 0xABC at t+2, so rsp_valid=4'b0100 and rsp_data=0xABC at t+3, for one cycle only.
- Full contention: req=4'b1111 held 8 cycles from reset. Grants are 0,1,2,3,0,1,2,3. Responses arrive in the same order, each 3 cycles after its grant.
- Rotation skip: last_gnt=1, req=4'b1001. Grant goes to 3 this cycle. Next cycle req=4'b0001 grants 0.
- Back-to-back: req1 and req2 alternate every cycle with distinct addresses. One grant per cycle, no bubbles. rsp_data matches the ROM contents for each address, tagged to the right requester.
- Reset mid-flight: grant requester 3, assert reset 1 cycle later. No rsp_valid[3] appears. After release, req=4'b1000 grants 3 normally.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among display layers.
// A one-hot tag pipeline matched to the ROM latency steers each returned word to its requester.
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 12,
    parameter int ROM_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   r_last_gnt;
    logic [NUM_REQ-1:0] r_tag [ROM_LATENCY];

    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_found;
    logic [NUM_REQ-1:0] w_gnt;

    // Search starts just after the last winner, so that winner drops to lowest priority.
    always_comb begin
        w_cand    = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_gnt     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_last_gnt) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        if (reset) begin
            w_found = 1'b0;
        end
        if (w_found) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign gnt      = w_gnt;
    assign rom_en   = w_found;
    assign rom_addr = w_found ? req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= IDX_W'(NUM_REQ - 1);
        end else if (w_found) begin
            r_last_gnt <= w_gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ROM_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= w_gnt;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // The last tag stage lines up with the ROM word for that grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= r_tag[ROM_LATENCY-1];
            if (|r_tag[ROM_LATENCY-1]) begin
                rsp_data <= rom_data;
            end
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: randomized requests against a round-robin model,
// responses checked by an independent monitor against a queue of expected (requester, word, cycle).
module tb_sprite_rom_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 14;
    localparam int DW   = 12;
    localparam int LAT  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   gnt;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;

    sprite_rom_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with LAT register stages.
    logic [DW-1:0] rom_mem [1 << AW];
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[rom_addr];
        for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           id;
        logic [DW-1:0] data;
        int           due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int ptr    = NREQ - 1;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference round-robin: first requester at or after ptr+1, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*AW-1:0] rand_addrs();
        logic [NREQ*AW-1:0] a;
        for (int i = 0; i < NREQ; i++) a[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
        return a;
    endfunction

    task automatic do_cycle(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a, input logic rst);
        int g;
        logic [AW-1:0] ga;
        exp_t e;
        reset    = rst;
        req      = r;
        req_addr = a;
        @(negedge clk);
        g  = rst ? -1 : pick(r);
        ga = (g < 0) ? '0 : a[g*AW +: AW];
        chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("rom_en", 32'(rom_en), (g < 0) ? 32'd0 : 32'd1);
        chk("rom_addr", 32'(rom_addr), 32'(ga));
        if (rst) begin
            ptr = NREQ - 1;
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > cyc) sb.delete(i);
        end else if (g >= 0) begin
            ptr    = g;
            e.id   = g;
            e.data = rom_mem[ga];
            e.due  = cyc + LAT + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: an expected entry due now must appear; otherwise nothing may.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end else if (rsp_valid !== '0) begin
                chk("rsp_valid_spurious", 32'(rsp_valid), 32'd0);
            end
        end
    end

    initial begin
        logic [NREQ*AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'($urandom);
        rom_mem[14'h0123] = 12'hABC;
        reset = 1'b1;
        req   = '0;
        req_addr = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int i = 0; i < 3; i++) do_cycle(4'b1111, rand_addrs(), 1'b1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);

        for (int i = 0; i < 3; i++) do_cycle(4'b0000, rand_addrs(), 1'b0);
        for (int i = 0; i < 8; i++) do_cycle(4'b1111, rand_addrs(), 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(4'b0000, rand_addrs(), 1'b0);

        a = rand_addrs();
        a[2*AW +: AW] = 14'h0123;
        do_cycle(4'b0100, a, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(4'b0000, rand_addrs(), 1'b0);

        do_cycle(4'b0010, rand_addrs(), 1'b0);
        do_cycle(4'b1001, rand_addrs(), 1'b0);
        do_cycle(4'b0001, rand_addrs(), 1'b0);

        for (int i = 0; i < 10; i++) do_cycle((i % 2) ? 4'b0100 : 4'b0010, rand_addrs(), 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(4'b0000, rand_addrs(), 1'b0);

        do_cycle(4'b1000, rand_addrs(), 1'b0);
        do_cycle(4'b0000, rand_addrs(), 1'b1);
        do_cycle(4'b1000, rand_addrs(), 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(4'b0000, rand_addrs(), 1'b0);

        for (int i = 0; i < 300; i++) begin
            do_cycle(NREQ'($urandom), rand_addrs(), ($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < LAT + 3; i++) do_cycle(4'b0000, rand_addrs(), 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
